// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC register and IF/ID pipeline register.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_id_i,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic        halted_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_cycles_o,
  output logic [31:0] perf_fetched_o
`endif
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fetch_en;

  // Priority in RUN: redirect > halt > stall > normal fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    fetch_en     = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_i) begin
          pc_d         = redirect_pc_i & 32'hFFFF_FFFC;
          ifid_pc_d    = 32'h0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (halt_id_i && ifid_valid_q) begin
          state_d      = HALTED;
          ifid_pc_d    = 32'h0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (!stall_i) begin
          fetch_en     = 1'b1;
          pc_d         = pc_q + 32'd4;
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_rdata_i;
          ifid_valid_d = 1'b1;
        end
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_cycles_q, perf_fetched_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_cycles_q  <= 32'h0;
      perf_fetched_q <= 32'h0;
    end else begin
      if (state_q == RUN) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (fetch_en)       perf_fetched_q <= perf_fetched_q + 32'd1;
    end
  end

  assign perf_cycles_o  = perf_cycles_q;
  assign perf_fetched_o = perf_fetched_q;
`else
  logic unused_fetch_en;
  assign unused_fetch_en = fetch_en;
`endif

  assign imem_addr_o  = pc_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign halted_o     = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table, hand sequences, random vs reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, halt_id;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, ifid_pc, ifid_instr;
  logic        ifid_valid, halted;
  logic [31:0] w_addr, w_rdata, w_ifid_pc, w_ifid_instr;
  logic        w_ifid_valid, w_halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_cycles, perf_fetched, w_perf_cycles, w_perf_fetched;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  fetch_stage dut (
    .clk_i(clk), .reset_i(reset), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc), .halt_id_i(halt_id),
    .ifid_pc_o(ifid_pc), .ifid_instr_o(ifid_instr), .ifid_valid_o(ifid_valid), .halted_o(halted)
`ifdef FETCH_PERF_EN
    , .perf_cycles_o(perf_cycles), .perf_fetched_o(perf_fetched)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk_i(clk), .reset_i(reset), .imem_addr_o(w_addr), .imem_rdata_i(w_rdata),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc), .halt_id_i(halt_id),
    .ifid_pc_o(w_ifid_pc), .ifid_instr_o(w_ifid_instr), .ifid_valid_o(w_ifid_valid), .halted_o(w_halted)
`ifdef FETCH_PERF_EN
    , .perf_cycles_o(w_perf_cycles), .perf_fetched_o(w_perf_fetched)
`endif
  );

  // Reference model: architectural view of the PC and the IF/ID slot.
  logic [31:0] m_pc = 32'h0, m_ipc = 32'h0, m_instr = NOP, m_cyc = 32'h0, m_fet = 32'h0;
  logic        m_valid = 1'b0, m_halted = 1'b0;

  task automatic model_update();
    if (reset) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      m_halted = 1'b0; m_cyc = 32'h0; m_fet = 32'h0;
    end else if (!m_halted) begin
      m_cyc = m_cyc + 1;
      if (redirect) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      end else if (halt_id && m_valid) begin
        m_halted = 1'b1;
        m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      end else if (!stall) begin
        m_ipc = m_pc; m_instr = mem_word(m_pc); m_valid = 1'b1;
        m_pc = m_pc + 4; m_fet = m_fet + 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] rp, input logic h);
    reset = r; stall = s; redirect = d; redirect_pc = rp; halt_id = h;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk_model();
    chk("rnd_addr",  imem_addr,  m_pc);
    chk("rnd_ipc",   ifid_pc,    m_ipc);
    chk("rnd_instr", ifid_instr, m_instr);
    chk("rnd_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    chk("rnd_halt",  {31'b0, halted},     {31'b0, m_halted});
`ifdef FETCH_PERF_EN
    chk("rnd_pcyc",  perf_cycles,  m_cyc);
    chk("rnd_pfet",  perf_fetched, m_fet);
`endif
  endtask

  typedef struct {
    logic        rst, stl, rdr, hlt;
    logic [31:0] rpc;
    logic [31:0] e_addr, e_ipc;
    logic        e_valid, e_halted;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [31:0] e_instr;
    drive(1, 0, 0, 0, 0);
    //            rst stl rdr hlt rpc            addr           ipc           v  h
    vecs[0]  = '{1, 0, 0, 0, 32'h0,         32'h0,         32'h0,        0, 0};
    vecs[1]  = '{0, 0, 0, 0, 32'h0,         32'h4,         32'h0,        1, 0};
    vecs[2]  = '{0, 0, 0, 0, 32'h0,         32'h8,         32'h4,        1, 0};
    vecs[3]  = '{0, 1, 0, 0, 32'h0,         32'h8,         32'h4,        1, 0};
    vecs[4]  = '{0, 1, 0, 0, 32'h0,         32'h8,         32'h4,        1, 0};
    vecs[5]  = '{0, 1, 0, 0, 32'h0,         32'h8,         32'h4,        1, 0};
    vecs[6]  = '{0, 0, 0, 0, 32'h0,         32'hC,         32'h8,        1, 0};
    vecs[7]  = '{0, 0, 0, 0, 32'h0,         32'h10,        32'hC,        1, 0};
    vecs[8]  = '{0, 1, 1, 0, 32'h43,        32'h40,        32'h0,        0, 0};
    vecs[9]  = '{0, 0, 0, 0, 32'h0,         32'h44,        32'h40,       1, 0};
    vecs[10] = '{0, 0, 1, 1, 32'h103,       32'h100,       32'h0,        0, 0};
    vecs[11] = '{0, 0, 0, 0, 32'h0,         32'h104,       32'h100,      1, 0};
    vecs[12] = '{0, 0, 0, 0, 32'h0,         32'h108,       32'h104,      1, 0};
    vecs[13] = '{0, 1, 0, 1, 32'h0,         32'h108,       32'h0,        0, 1};
    vecs[14] = '{0, 0, 1, 0, 32'h200,       32'h108,       32'h0,        0, 1};
    vecs[15] = '{0, 0, 0, 1, 32'h0,         32'h108,       32'h0,        0, 1};
    vecs[16] = '{1, 1, 1, 1, 32'h300,       32'h0,         32'h0,        0, 0};
    vecs[17] = '{0, 0, 0, 1, 32'h0,         32'h4,         32'h0,        1, 0};
    vecs[18] = '{0, 0, 0, 0, 32'hFFFF_FFFC, 32'h8,         32'h4,        1, 0};
    vecs[19] = '{0, 0, 1, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0,        0, 0};

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].rpc, vecs[i].hlt);
      step();
      e_instr = vecs[i].e_valid ? mem_word(vecs[i].e_ipc) : NOP;
      chk("tbl_addr",  imem_addr,  vecs[i].e_addr);
      chk("tbl_ipc",   ifid_pc,    vecs[i].e_ipc);
      chk("tbl_instr", ifid_instr, e_instr);
      chk("tbl_valid", {31'b0, ifid_valid}, {31'b0, vecs[i].e_valid});
      chk("tbl_halt",  {31'b0, halted},     {31'b0, vecs[i].e_halted});
    end
    // PC wraps through 0 after the last word of the address space
    drive(0, 0, 0, 0, 0);
    step();
    chk("wrap_ipc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    // Halt at ifid_pc 0x10, then frozen for 10 cycles despite redirect pulses
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    chk("pre_halt_ipc", ifid_pc, 32'h10);
    drive(0, 0, 0, 0, 1); step();
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_valid", {31'b0, ifid_valid}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      drive(0, i[0], ~i[0], 32'h0000_0800, i[1]);
      step();
      chk("halt_frozen_addr", imem_addr, 32'h14);
      chk("halt_frozen_valid", {31'b0, ifid_valid}, 32'h0);
      chk("halt_stays", {31'b0, halted}, 32'h1);
    end
    drive(1, 0, 0, 0, 0); step();
    chk("rst_after_halt_addr", imem_addr, 32'h0);
    chk("rst_after_halt_flag", {31'b0, halted}, 32'h0);
    drive(0, 0, 0, 0, 0); step();
    chk("restart_ipc", ifid_pc, 32'h0);
    chk("restart_valid", {31'b0, ifid_valid}, 32'h1);

    // Non-zero RESET_PC wraps through 0
    drive(1, 0, 0, 0, 0); step();
    chk("w_rst_addr", w_addr, 32'hFFFF_FFF8);
    drive(0, 0, 0, 0, 0);
    step(); chk("w_ipc0", w_ifid_pc, 32'hFFFF_FFF8);
    chk("w_instr0", w_ifid_instr, mem_word(32'hFFFF_FFF8));
    step(); chk("w_ipc1", w_ifid_pc, 32'hFFFF_FFFC);
    step(); chk("w_ipc2", w_ifid_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("w_pfet3", w_perf_fetched, 32'd3);
    chk("w_pcyc3", w_perf_cycles, 32'd3);
`endif
    drive(0, 0, 0, 0, 1); step();
    chk("w_halted", {31'b0, w_halted}, 32'h1);
    for (int i = 0; i < 3; i++) step();
`ifdef FETCH_PERF_EN
    chk("w_pfet_frozen", w_perf_fetched, 32'd3);
    chk("w_pcyc_frozen", w_perf_cycles, 32'd4);
`endif
    chk("w_addr_frozen", w_addr, 32'h4);

    // Randomized run against the reference model
    drive(1, 0, 0, 0, 0); step(); chk_model();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 24) == 0));
      step();
      chk_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the RISC-V core. Holds the PC, drives the instruction-memory address, and latches the fetched word plus its PC into the IF/ID register that feeds the opcode decoder. Handles load-use stalls, EX-stage branch/jump redirects, and the halt opcode reported back from decode by stopping fetch permanently until reset.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013: bubble word (addi x0,x0,0) inserted on flush and reset.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  instruction memory byte address; equals PC register.
- imem_rdata  in  32  instruction word at imem_addr, valid in the same cycle.
- stall  in  1  from hazard unit; hold PC and IF/ID.
- redirect  in  1  taken branch / jal / jalr resolved in EX.
- redirect_pc  in  32  redirect target; bits [1:0] ignored, treated as 0.
- halt_id  in  1  decoder halt output for the instruction currently in IF/ID.
- ifid_pc  out  32  PC of instruction in IF/ID.
- ifid_instr  out  32  instruction in IF/ID, drives decoder opcode field.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- halted  out  1  fetch stopped by halt.
- perf_cycles  out  32  only with FETCH_PERF_EN.
- perf_fetched  out  32  only with FETCH_PERF_EN.

## Operation
- Two-state FSM: RUN, HALTED. Reset -> RUN.
- Priority per cycle in RUN: reset > redirect > halt > stall > normal.
- redirect: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (instr NOP_INSTR, valid 0, pc 0). Overrides stall and halt_id (instruction in ID is wrong-path).
- halt_id && ifid_valid, no redirect: FSM -> HALTED; PC frozen; IF/ID <= bubble. Taken even when stall=1. halt_id with ifid_valid=0 ignored.
- stall, no redirect/halt: PC and IF/ID unchanged.
- normal: IF/ID <= {imem_rdata, PC, valid 1}; PC <= PC + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- HALTED: PC, IF/ID (bubble) frozen; stall, redirect, halt_id ignored; halted=1. Exit only via reset.
- Reset values: PC=RESET_PC, imem_addr=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_valid=0, halted=0, perf counters 0.

## Timing
- imem_addr combinational from PC register; no memory wait states.
- Fetch-to-decode latency 1 cycle: word addressed in cycle N appears on ifid_instr in N+1.
- First valid instruction: reset low in cycle 0 -> ifid_valid=1 with RESET_PC word in cycle 1.
- Redirect in cycle N: imem_addr=target in N+1, bubble in IF/ID in N+1, target instruction in IF/ID in N+2 (2-cycle taken penalty counting EX bubble).
- halt_id in cycle N: halted=1 and bubble in IF/ID from N+1; no instruction after halt ever reaches IF/ID.
- reset asserted in HALTED or mid-stall: reset values in the next cycle, RUN resumes.

## Configuration
- FETCH_PERF_EN defined: perf_cycles increments every cycle in RUN (frozen in HALTED); perf_fetched increments on every normal latch with ifid_valid becoming/staying 1 for a new word. Both 32-bit, wrap to 0, cleared by reset.
- Undefined: both ports and counters absent; no other behaviour change.

## Test plan
- Reset, memory filled with PC-tagged words, no stalls -> ifid_pc 0,4,8,12 on cycles 1-4, ifid_valid=1, ifid_instr = word at each PC.
- stall=1 for 3 cycles at PC=8 -> ifid_pc stays 4, imem_addr stays 8 for 3 cycles, then sequence resumes 8,12 with no skipped or duplicated word.
- redirect=1, redirect_pc=32'h0000_0043 with stall=1 same cycle -> next cycle imem_addr=0x40, ifid_valid=0; following cycle ifid_pc=0x40.
- halt_id=1 with ifid_valid=1 at ifid_pc=0x10 -> halted=1, ifid_valid=0, imem_addr frozen at 0x14 for 10 cycles despite redirect pulses; reset then restarts at RESET_PC.
- halt_id=1 and redirect=1 same cycle -> no halt, halted=0, fetch resumes at redirect target.
- RESET_PC=32'hFFFF_FFF8 -> ifid_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; with FETCH_PERF_EN, perf_fetched=3, perf_cycles=3 after 3 cycles, both frozen after halt.
